// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the architectural PC and fetches one instruction per commit
// from imem over a req/gnt + rvalid handshake, holding the word for decode.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   next_pc_i, wb_valid_i       next PC and commit strobe from writeback
//   imem_req_o, imem_addr_o     fetch request and address (address = pc_o)
//   imem_gnt_i                  imem accepted the request
//   imem_rvalid_i, imem_rdata_i returned instruction word
//   pc_o, insn_o, insn_valid_o  PC and instruction held for decode
//   error_o                     sticky misaligned-next_pc flag
//   fetch_cnt_o                 completed fetch count, wraps modulo 2^32
module fetch_pc_unit #(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] next_pc_i,
    input  logic              wb_valid_i,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic              insn_valid_o,
    output logic              error_o,
    output logic [31:0]       fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [AWIDTH-1:0] pc_n;
    logic [DWIDTH-1:0] insn_n;
    logic              error_n;
    logic [31:0]       fetch_cnt_n;

    assign imem_addr_o = pc_o;

    // Next-state and datapath update
    always_comb begin
        state_n     = state;
        pc_n        = pc_o;
        insn_n      = insn_o;
        error_n     = error_o;
        fetch_cnt_n = fetch_cnt_o;
        case (state)
            S_REQ: begin
                // The registered request is low for one cycle after reset; a grant then is not ours.
                if (imem_req_o && imem_gnt_i) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    insn_n      = imem_rdata_i;
                    fetch_cnt_n = fetch_cnt_o + 32'd1;
                    state_n     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (wb_valid_i) begin
                    if (next_pc_i[1:0] == 2'b00) begin
                        pc_n    = next_pc_i;
                        state_n = S_REQ;
                    end else begin
                        error_n = 1'b1;
                        state_n = S_HALT;
                    end
                end
            end
            default: begin
                state_n = S_HALT;
            end
        endcase
    end

    // State and output registers; req/valid are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_REQ;
            pc_o         <= BASEADDR;
            insn_o       <= '0;
            insn_valid_o <= 1'b0;
            imem_req_o   <= 1'b0;
            error_o      <= 1'b0;
            fetch_cnt_o  <= '0;
        end else begin
            state        <= state_n;
            pc_o         <= pc_n;
            insn_o       <= insn_n;
            insn_valid_o <= (state_n == S_HOLD);
            imem_req_o   <= (state_n == S_REQ);
            error_o      <= error_n;
            fetch_cnt_o  <= fetch_cnt_n;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; inputs change and outputs are
// checked on the falling edge, the DUT acts on the rising edge.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc_i;
    logic        wb_valid_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic        insn_valid_o;
    logic        error_o;
    logic [31:0] fetch_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .next_pc_i    (next_pc_i),
        .wb_valid_i   (wb_valid_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .pc_o         (pc_o),
        .insn_o       (insn_o),
        .insn_valid_o (insn_valid_o),
        .error_o      (error_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; next_pc_i = '0; wb_valid_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        cyc(); cyc();

        // Reset values
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(insn_valid_o), 32'd0);
        chk("rst_pc", pc_o, 32'h0100_0000);
        chk("rst_insn", insn_o, 32'h0);
        chk("rst_err", 32'(error_o), 32'd0);
        chk("rst_cnt", fetch_cnt_o, 32'd0);

        // 1: first fetch after reset release
        reset = 1'b0; imem_gnt_i = 1'b1;
        cyc();
        chk("t1_req", 32'(imem_req_o), 32'd1);
        chk("t1_addr", imem_addr_o, 32'h0100_0000);
        cyc();
        chk("t1_wait_req", 32'(imem_req_o), 32'd0);
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
        cyc();
        imem_rvalid_i = 1'b0;
        chk("t1_valid", 32'(insn_valid_o), 32'd1);
        chk("t1_insn", insn_o, 32'h0000_0013);
        chk("t1_cnt", fetch_cnt_o, 32'd1);

        // 2: sequential commit then branch commit
        wb_valid_i = 1'b1; next_pc_i = 32'h0100_0004;
        cyc();
        wb_valid_i = 1'b0;
        chk("t2_req", 32'(imem_req_o), 32'd1);
        chk("t2_addr", imem_addr_o, 32'h0100_0004);
        chk("t2_valid_drop", 32'(insn_valid_o), 32'd0);
        imem_gnt_i = 1'b1;
        cyc();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0040_0093;
        cyc();
        imem_rvalid_i = 1'b0;
        chk("t2_insn", insn_o, 32'h0040_0093);
        chk("t2_cnt", fetch_cnt_o, 32'd2);
        wb_valid_i = 1'b1; next_pc_i = 32'h0100_0040;
        cyc();
        wb_valid_i = 1'b0;
        chk("t2_br_req", 32'(imem_req_o), 32'd1);
        chk("t2_br_addr", imem_addr_o, 32'h0100_0040);

        // 3 + 6: grant withheld 5 cycles, commit strobe in REQ ignored
        for (int i = 0; i < 5; i++) begin
            wb_valid_i = (i == 0); next_pc_i = 32'h0200_0000;
            cyc();
            chk("t3_req_held", 32'(imem_req_o), 32'd1);
            chk("t3_addr_stable", imem_addr_o, 32'h0100_0040);
        end
        wb_valid_i = 1'b0;
        imem_gnt_i = 1'b1;
        cyc();
        imem_gnt_i = 1'b0;
        // rvalid delayed 4 cycles, commit strobe in WAIT ignored
        for (int i = 0; i < 4; i++) begin
            wb_valid_i = (i == 1); next_pc_i = 32'h0300_0000;
            cyc();
            chk("t3_wait_valid", 32'(insn_valid_o), 32'd0);
            chk("t3_wait_req", 32'(imem_req_o), 32'd0);
            chk("t6_pc_wait", pc_o, 32'h0100_0040);
        end
        wb_valid_i = 1'b0;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0011;
        cyc();
        imem_rvalid_i = 1'b0;
        chk("t3_valid", 32'(insn_valid_o), 32'd1);
        chk("t3_insn", insn_o, 32'h0000_0011);
        chk("t3_cnt", fetch_cnt_o, 32'd3);

        // 6: fetch counter wrap
        force dut.fetch_cnt_o = 32'hFFFF_FFFF;
        cyc();
        release dut.fetch_cnt_o;
        cyc();
        chk("t6_cnt_preload", fetch_cnt_o, 32'hFFFF_FFFF);
        wb_valid_i = 1'b1; next_pc_i = 32'h0100_0044;
        cyc();
        wb_valid_i = 1'b0; imem_gnt_i = 1'b1;
        cyc();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0033;
        cyc();
        imem_rvalid_i = 1'b0;
        chk("t6_cnt_wrap", fetch_cnt_o, 32'd0);
        chk("t6_insn", insn_o, 32'h0000_0033);

        // 4: misaligned commit halts with sticky error
        wb_valid_i = 1'b1; next_pc_i = 32'h0100_0042;
        cyc();
        chk("t4_err", 32'(error_o), 32'd1);
        chk("t4_valid", 32'(insn_valid_o), 32'd0);
        chk("t4_pc", pc_o, 32'h0100_0044);
        next_pc_i = 32'h0100_0048; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_halt_req", 32'(imem_req_o), 32'd0);
            chk("t4_halt_err", 32'(error_o), 32'd1);
            chk("t4_halt_pc", pc_o, 32'h0100_0044);
        end
        wb_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        reset = 1'b1;
        cyc();
        chk("t4_rst_err", 32'(error_o), 32'd0);
        chk("t4_rst_pc", pc_o, 32'h0100_0000);
        chk("t4_rst_cnt", fetch_cnt_o, 32'd0);

        // 5: reset in WAIT, stray rvalid afterwards is dropped
        reset = 1'b0;
        cyc();
        imem_gnt_i = 1'b1;
        cyc();
        imem_gnt_i = 1'b0;
        chk("t5_in_wait", 32'(imem_req_o), 32'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid_i = 1'b0;
        chk("t5_valid", 32'(insn_valid_o), 32'd0);
        chk("t5_insn", insn_o, 32'h0);
        chk("t5_req", 32'(imem_req_o), 32'd1);
        chk("t5_addr", imem_addr_o, 32'h0100_0000);
        chk("t5_cnt", fetch_cnt_o, 32'd0);
        imem_gnt_i = 1'b1;
        cyc();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
        cyc();
        imem_rvalid_i = 1'b0;
        chk("t5_refetch", insn_o, 32'h0000_0013);
        chk("t5_cnt1", fetch_cnt_o, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
